// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host receiver and transmitter.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Parity bit that makes data+parity contain an odd number of ones.
  function automatic logic odd_parity_bit(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on both lines, ps2c glitch filter,
// and registered fall/rise strobes of the filtered clock.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2d_o,
  output logic clk_filt_o,
  output logic fall_o,
  output logic rise_o
);

  logic [1:0]            c_sync_q, c_sync_d;
  logic [1:0]            d_sync_q, d_sync_d;
  logic [FILTER_LEN-1:0] shift_q, shift_d;
  logic                  filt_q, filt_d;
  logic                  fall_q, fall_d;
  logic                  rise_q, rise_d;

  // Filtered clock only moves once the whole window agrees; anything else holds.
  always_comb begin
    c_sync_d = {c_sync_q[0], ps2c_i};
    d_sync_d = {d_sync_q[0], ps2d_i};
    shift_d  = {shift_q[FILTER_LEN-2:0], c_sync_q[1]};
    filt_d   = filt_q;
    if (&shift_d) begin
      filt_d = 1'b1;
    end else if (~|shift_d) begin
      filt_d = 1'b0;
    end
    fall_d = filt_q & ~filt_d;
    rise_d = ~filt_q & filt_d;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      shift_q  <= '1;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      c_sync_q <= c_sync_d;
      d_sync_q <= d_sync_d;
      shift_q  <= shift_d;
      filt_q   <= filt_d;
      fall_q   <= fall_d;
      rise_q   <= rise_d;
    end
  end

  assign ps2d_o     = d_sync_q[1];
  assign clk_filt_o = filt_q;
  assign fall_o     = fall_q;
  assign rise_o     = rise_q;

endmodule

// File: rtl/ps2_rx.sv
// Host-side PS/2 receiver: one byte per device-to-host frame, with parity/framing
// error flags and a stall timeout.
//
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (fall with data 0)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the parity bit
//   ST_STOP   | checking the stop bit, then delivering the byte
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_en_i,
  input  logic       ps2d_i,
  input  logic       ps2c_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       rx_timeout_o,
  output logic       rx_idle_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic fall;
  logic d_bit;
  logic c_level_unused;
  logic c_rise_unused;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .ps2c_i    (ps2c_i),
    .ps2d_i    (ps2d_i),
    .ps2d_o    (d_bit),
    .clk_filt_o(c_level_unused),
    .fall_o    (fall),
    .rise_o    (c_rise_unused)
  );

  ps2_state_e               state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     par_q, par_d;
  logic [PS2_DATA_BITS-1:0] data_q, data_d;
  logic                     done_q, done_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     tout_q, tout_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    data_d    = data_q;
    done_d    = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    tout_d    = 1'b0;

    // Losing the bus to the transmitter overrides everything, including a stop-bit fall.
    if (state_q != ST_IDLE && !rx_en_i) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (state_q == ST_IDLE) begin
      timer_d = '0;
      if (fall && rx_en_i && !d_bit) begin
        state_d   = ST_DATA;
        bit_cnt_d = 3'(PS2_DATA_BITS - 1);
      end
    end else if (fall) begin
      timer_d = '0;
      unique case (state_q)
        ST_DATA: begin
          shreg_d = {d_bit, shreg_q[PS2_DATA_BITS-1:1]};
          if (bit_cnt_q == 3'd0) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        ST_PARITY: begin
          par_d   = d_bit;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          data_d  = shreg_q;
          perr_d  = (par_q != odd_parity_bit(shreg_q));
          ferr_d  = ~d_bit;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timer_q == TIMER_LAST) begin
      state_d = ST_IDLE;
      timer_d = '0;
      tout_d  = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      timer_q   <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      timer_q   <= timer_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      data_q    <= data_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      tout_q    <= tout_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_done_o    = done_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign rx_timeout_o = tout_q;
  assign rx_idle_o    = (state_q == ST_IDLE);

endmodule
